load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits directly upstream of DataMemory: takes byte/half/word load-store requests from the EX stage and
//  turns them into word accesses on DataMemory's word-indexed port (mem_address/mem_write_data/mem_read/mem_write).
//  Loads: lane extraction plus sign/zero extension. Sub-word stores: 2-cycle read-modify-write.
//  Misaligned or out-of-range accesses never reach memory and return an error response.
// PARAMETERS
//  MEM_WORDS  1024  words in DataMemory; word index >= MEM_WORDS is out of range
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   synchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit idle, can accept a request
//  req_write       in   1   1 = store, 0 = load
//  req_funct3      in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-aligned
//  resp_valid      out  1   response present
//  resp_ready      in   1   consumer takes response
//  resp_rdata      out  32  load result, extended; 0 for stores and errors
//  resp_err        out  1   misaligned, out-of-range, or illegal funct3
//  mem_address     out  32  word index = {2'b00, addr[31:2]}
//  mem_write_data  out  32  full word to write
//  mem_read        out  1   DataMemory read enable (combinational read)
//  mem_write       out  1   DataMemory write enable (written at posedge)
//  mem_read_data   in   32  DataMemory read data
// BEHAVIOUR
//  - On reset: state IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata = 0.
//  - mem_read and mem_write are forced 0 in any cycle where reset=1, so an aborted RMW never writes.
//  - FSM states: IDLE, ACCESS, WRITE, RESP.
//  - IDLE: req_ready=1. On req_valid, latch write, funct3, addr and wdata, then check:
//      - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
//      - out of range: addr[31:2] >= MEM_WORDS
//      - illegal funct3: loads 011/110/111; stores anything other than 000/001/010
//      - any of these: go to RESP with err=1, no memory access. Otherwise go to ACCESS.
//  - ACCESS: mem_address valid.
//      - Load: mem_read=1; latch extracted lane. Byte lane = addr[1:0]; half lane = addr[1].
//        Signed loads sign-extend, unsigned loads zero-extend. Go to RESP.
//      - SW: mem_write=1, mem_write_data=wdata. Go to RESP.
//      - SB/SH: mem_read=1; latch merged word (selected lane replaced by wdata[7:0] or wdata[15:0],
//        other lanes from mem_read_data). Go to WRITE.
//  - WRITE: mem_write=1, mem_write_data = merged word. Go to RESP.
//  - RESP: resp_valid=1, resp_rdata and resp_err held stable. On resp_ready go to IDLE
//    (resp_valid=0 next cycle). No new request accepted in RESP.
//  - Latency from accept edge to resp_valid:
//      - load and SW: 2 cycles
//      - SB/SH: 3 cycles
//      - error: 1 cycle
//  - At most one request in flight. Upper address bits above index range are checked by the range test, not ignored.
//  - mem_address, mem_write_data are 0 outside ACCESS/WRITE; mem_read/mem_write never both 1.
// TESTING
//  - SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write one cycle at index 4; load resp_rdata=0xDEADBEEF, err=0.
//  - Word 0x80FF7F01 at index 1: LB 0x07 -> 0xFFFFFF80; LBU 0x07 -> 0x00000080; LH 0x04 -> 0x00007F01; LHU 0x06 -> 0x000080FF.
//  - SB addr 0x05 data 0x000000AA over word 0x11223344 -> read cycle then write cycle; index 1 becomes 0x1122AA44.
//  - LW 0x02, SH 0x03, LW 0x1000 (MEM_WORDS=1024) -> resp_err=1 one cycle after accept; mem_read/mem_write never asserted.
//  - resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable; req_ready=0 throughout.
//  - reset asserted in the WRITE cycle of an SB -> mem_write=0 that cycle; memory unchanged; next cycle IDLE, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a word-indexed DataMemory.
//   Loads extract a lane and sign/zero extend it. SW writes in one access cycle.
//   SB/SH do a read-modify-write (read cycle, then write cycle). Misaligned,
//   out-of-range and illegal-funct3 requests are answered with resp_err and
//   never touch memory.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_write/req_funct3        store flag and access size/sign code
//   req_addr/req_wdata          byte address, right-aligned store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata/resp_err         extended load data (0 for stores/errors), error flag
//   mem_address/mem_write_data  word index and full write word toward DataMemory
//   mem_read/mem_write          DataMemory enables (never both high)
//   mem_read_data               DataMemory combinational read data
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned IDX_W = 30;
    localparam logic [IDX_W-1:0] MEM_WORDS_IDX = IDX_W'(MEM_WORDS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic        write_q,  write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] merge_q,  merge_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic        req_misalign_c;
    logic        req_oor_c;
    logic        req_illegal_c;
    logic [4:0]  shamt_c;
    logic [31:0] rd_shifted_c;
    logic [31:0] lane_mask_c;
    logic [31:0] merged_c;
    logic [31:0] load_ext_c;

    // Request screening: size alignment, index range (all upper bits count), funct3 legality
    always_comb begin
        req_misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_oor_c      = (req_addr[31:2] >= MEM_WORDS_IDX);
        if (req_write) begin
            req_illegal_c = !((req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                              (req_funct3 == 3'b010));
        end else begin
            req_illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
    end

    // Lane extraction and sub-word merge, both keyed by the byte offset of the latched address
    always_comb begin
        shamt_c      = {addr_q[1:0], 3'b000};
        rd_shifted_c = mem_read_data >> shamt_c;
        lane_mask_c  = ((funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt_c;
        merged_c     = (mem_read_data & ~lane_mask_c) | ((wdata_q << shamt_c) & lane_mask_c);
        case (funct3_q)
            3'b000:  load_ext_c = {{24{rd_shifted_c[7]}}, rd_shifted_c[7:0]};
            3'b001:  load_ext_c = {{16{rd_shifted_c[15]}}, rd_shifted_c[15:0]};
            3'b010:  load_ext_c = rd_shifted_c;
            3'b100:  load_ext_c = {24'h0, rd_shifted_c[7:0]};
            3'b101:  load_ext_c = {16'h0, rd_shifted_c[15:0]};
            default: load_ext_c = 32'h0;
        endcase
    end

    // Next-state and memory-side decode
    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        merge_d        = merge_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = req_misalign_c || req_oor_c || req_illegal_c;
                    state_d  = (req_misalign_c || req_oor_c || req_illegal_c) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_address = {2'b00, addr_q[31:2]};
                if (!write_q) begin
                    mem_read = 1'b1;
                    rdata_d  = load_ext_c;
                    state_d  = S_RESP;
                end else if (funct3_q == 3'b010) begin
                    mem_write      = 1'b1;
                    mem_write_data = wdata_q;
                    state_d        = S_RESP;
                end else begin
                    mem_read = 1'b1;
                    merge_d  = merged_c;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_address    = {2'b00, addr_q[31:2]};
                mem_write      = 1'b1;
                mem_write_data = merge_q;
                state_d        = S_RESP;
            end
            default: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // A reset cycle must never reach memory, so an interrupted RMW leaves it untouched
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives load_store_unit against a behavioural DataMemory and a
// transaction-level reference model of memory contents and responses.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dmem    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DataMemory: combinational read, write at posedge
    always @(posedge clk) begin
        if (mem_write && (mem_address < 32'(MEM_WORDS)))
            dmem[mem_address[9:0]] <= mem_write_data;
    end
    assign mem_read_data = (mem_read && (mem_address < 32'(MEM_WORDS))) ?
                           dmem[mem_address[9:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: what one request should do, worked out from byte arithmetic on ref_mem
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] widx, output logic [31:0] wdat);
        logic legal;
        longint unsigned nbytes, idx, sh, mask, word, val;
        legal  = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = 64'd1 << f3[1:0];
        idx    = 64'(addr) / 64'd4;
        err    = !legal || ((64'(addr) % nbytes) != 64'd0) || (idx >= 64'(MEM_WORDS));
        rdata  = 32'h0;
        lat    = 1;
        nrd    = 0;
        nwr    = 0;
        widx   = 32'h0;
        wdat   = 32'h0;
        if (!err) begin
            word = 64'(ref_mem[int'(idx)]);
            sh   = 64'd8 * (64'(addr) % 64'd4);
            mask = (64'd1 << (64'd8 * nbytes)) - 64'd1;
            if (!wr) begin
                val = (word >> sh) & mask;
                if (!f3[2] && (nbytes < 64'd4) && (val >= (mask + 64'd1) / 64'd2))
                    val = val + (64'hFFFF_FFFF - mask);
                rdata = 32'(val);
                lat   = 2;
                nrd   = 1;
            end else begin
                if (nbytes == 64'd4) begin
                    val = 64'(wd);
                    lat = 2;
                end else begin
                    val = (word & ~(mask << sh)) | ((64'(wd) & mask) << sh);
                    lat = 3;
                    nrd = 1;
                end
                val  = val & 64'hFFFF_FFFF;
                nwr  = 1;
                widx = 32'(idx);
                wdat = 32'(val);
                ref_mem[int'(idx)] = 32'(val);
            end
        end
    endtask

    // One full transaction with an optional response back-pressure of `stall` cycles
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall, output logic [31:0] rdata);
        logic        e_err;
        logic [31:0] e_rdata, e_widx, e_wdat, widx, wdat;
        int          e_lat, e_nrd, e_nwr, lat, nrd, nwr, both;
        model(wr, f3, addr, wd, e_err, e_rdata, e_lat, e_nrd, e_nwr, e_widx, e_wdat);
        rdata = 32'hx;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        nrd  = 0;
        nwr  = 0;
        both = 0;
        widx = 32'h0;
        wdat = 32'h0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                widx = mem_address;
                wdat = mem_write_data;
            end
            if (mem_read && mem_write) both++;
            if (resp_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("mem_read_cycles", 32'(nrd), 32'(e_nrd));
        check("mem_write_cycles", 32'(nwr), 32'(e_nwr));
        check("rd_wr_overlap", 32'(both), 32'h0);
        if (e_nwr != 0) begin
            check("write_index", widx, e_widx);
            check("write_word", wdat, e_wdat);
        end
        if (lat != 0) begin
            rdata = resp_rdata;
            check("resp_err", 32'(resp_err), 32'(e_err));
            check("resp_rdata", resp_rdata, e_rdata);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stall_resp_valid", 32'(resp_valid), 32'h1);
                check("stall_resp_rdata", resp_rdata, e_rdata);
                check("stall_req_ready", 32'(req_ready), 32'h0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
            @(negedge clk);
            check("resp_valid_drop", 32'(resp_valid), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        wr;
        int          sel;
        logic [2:0]  load_codes [5];
        load_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_address", mem_address, 32'h0);

        // Fill the working window (words 0..15) through the unit itself
        for (int i = 0; i < 16; i++) do_req(1'b1, 3'b010, 32'(i * 4), $urandom, 0, r);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, r);
        check("sw_rdata_zero", r, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, r);
        check("lw_deadbeef", r, 32'hDEAD_BEEF);

        do_req(1'b1, 3'b010, 32'h04, 32'h80FF_7F01, 0, r);
        do_req(1'b0, 3'b000, 32'h07, 32'h0, 0, r);
        check("lb_07", r, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h07, 32'h0, 0, r);
        check("lbu_07", r, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h04, 32'h0, 0, r);
        check("lh_04", r, 32'h0000_7F01);
        do_req(1'b0, 3'b101, 32'h06, 32'h0, 0, r);
        check("lhu_06", r, 32'h0000_80FF);

        do_req(1'b1, 3'b010, 32'h04, 32'h1122_3344, 0, r);
        do_req(1'b1, 3'b000, 32'h05, 32'h0000_00AA, 0, r);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, 0, r);
        check("sb_merge", r, 32'h1122_AA44);
        do_req(1'b1, 3'b001, 32'h06, 32'hFFFF_5A5A, 0, r);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, 0, r);
        check("sh_merge", r, 32'h5A5A_AA44);

        // Error cases: response one cycle after accept, no memory traffic
        do_req(1'b0, 3'b010, 32'h02, 32'h0, 0, r);
        do_req(1'b1, 3'b001, 32'h03, 32'h1234, 0, r);
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, 0, r);
        do_req(1'b0, 3'b011, 32'h08, 32'h0, 0, r);
        do_req(1'b1, 3'b100, 32'h08, 32'h0, 0, r);
        do_req(1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0, 0, r);
        do_req(1'b0, 3'b010, 32'(MEM_WORDS * 4 - 4), 32'h0, 0, r);

        // Back-pressure on the response
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, r);
        do_req(1'b1, 3'b000, 32'h01, 32'h77, 5, r);

        // Reset landing in the write cycle of an SB must leave memory untouched
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h09;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_read_phase", 32'(mem_read), 32'h1);
        @(negedge clk);
        check("rmw_write_phase", 32'(mem_write), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_kills_write", 32'(mem_write), 32'h0);
        check("rst_kills_read", 32'(mem_read), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'h1);
        check("post_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("post_rst_mem_word", dmem[2], ref_mem[2]);

        // Randomised traffic, mostly legal and in the working window
        for (int t = 0; t < 250; t++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 8) f3 = wr ? 3'($urandom_range(0, 2)) : load_codes[$urandom_range(0, 4)];
            else         f3 = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            if (sel < 8) addr = 32'($urandom_range(0, 63));
            else         addr = $urandom | 32'h0000_1000;
            do_req(wr, f3, addr, $urandom, int'($urandom_range(0, 2)), r);
        end

        for (int i = 0; i < 16; i++) check("final_mem_word", dmem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
